// File: rtl/board_sram_arbiter.sv
// rtl/board_sram_arbiter.sv - VGA/game arbiter for the single-port board SRAM, VGA has fixed-latency priority
// Optional STARVE_GUARD_EN: forces a game grant after STARVE_LIMIT blocked cycles, dropping that VGA slot.
module board_sram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 2,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic [DATA_W-1:0] game_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_VGA,
    GRANT_GAME,
    GAME_WAIT
  } state_t;

  state_t state;
  logic   busy;
  logic   s1_drop;
  logic   s2_vga;
  logic   s2_drop;
  logic   s2_game;
  logic   s2_we;
  logic   starve_force;
  logic   grant_game;
  logic   grant_vga;

  // The ack cycle also blocks a grant so a requester dropping req on ack is served once.
  assign grant_game = game_req && !busy && !game_ack && (!vga_req || starve_force);
  assign grant_vga  = vga_req && !grant_game;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign starve_force = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_game) begin
      starve_cnt <= '0;
    end else if (game_req && !busy && !game_ack) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      s1_drop    <= 1'b0;
      s2_vga     <= 1'b0;
      s2_drop    <= 1'b0;
      s2_game    <= 1'b0;
      s2_we      <= 1'b0;
      sram_addr  <= '0;
      sram_we    <= 1'b0;
      sram_wdata <= '0;
      vga_data   <= '0;
      vga_valid  <= 1'b0;
      game_ack   <= 1'b0;
      game_rdata <= '0;
    end else begin
      sram_we <= 1'b0;
      s1_drop <= 1'b0;
      if (grant_vga) begin
        state     <= GRANT_VGA;
        sram_addr <= vga_addr;
      end else if (grant_game) begin
        state      <= GRANT_GAME;
        sram_addr  <= game_addr;
        sram_we    <= game_we;
        sram_wdata <= game_wdata;
        s1_drop    <= vga_req;
      end else if (busy && !game_ack) begin
        state <= GAME_WAIT;
      end else begin
        state <= IDLE;
      end

      if (grant_game) begin
        busy <= 1'b1;
      end else if (game_ack) begin
        busy <= 1'b0;
      end

      // A dropped VGA slot still travels down the pipe so the pixel stream keeps its cadence.
      s2_vga  <= (state == GRANT_VGA) || s1_drop;
      s2_drop <= s1_drop;
      s2_game <= (state == GRANT_GAME);
      s2_we   <= sram_we;

      vga_valid <= s2_vga;
      if (s2_vga && !s2_drop) begin
        vga_data <= sram_rdata;
      end
      game_ack <= s2_game;
      if (s2_game && !s2_we) begin
        game_rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_board_sram_arbiter.sv
// tb/tb_board_sram_arbiter.sv - directed vector bench for board_sram_arbiter with a behavioural SRAM
module tb_board_sram_arbiter;

  logic        CLOCK_50;
  logic        reset;
  logic        vga_req;
  logic [12:0] vga_addr;
  logic [1:0]  vga_data;
  logic        vga_valid;
  logic        game_req;
  logic        game_we;
  logic [12:0] game_addr;
  logic [1:0]  game_wdata;
  logic        game_ack;
  logic [1:0]  game_rdata;
  logic [12:0] sram_addr;
  logic        sram_we;
  logic [1:0]  sram_wdata;
  logic [1:0]  sram_rdata;

  logic [1:0]  mem [0:8191];
  logic        preload;

  int n_vec;
  int n_bad;

  board_sram_arbiter #(
    .ADDR_W(13),
    .DATA_W(2),
    .STARVE_LIMIT(4)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_data  (vga_data),
    .vga_valid (vga_valid),
    .game_req  (game_req),
    .game_we   (game_we),
    .game_addr (game_addr),
    .game_wdata(game_wdata),
    .game_ack  (game_ack),
    .game_rdata(game_rdata),
    .sram_addr (sram_addr),
    .sram_we   (sram_we),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (preload) begin
      mem[0] <= 2'd0;
      mem[1] <= 2'd1;
      mem[2] <= 2'd2;
      mem[3] <= 2'd3;
    end else begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    logic        vr;
    logic [12:0] va;
    logic        gr;
    logic        gw;
    logic [12:0] ga;
    logic [1:0]  gd;
    logic        e_we;
    logic [12:0] e_addr;
    logic        e_vv;
    logic [1:0]  e_vd;
    logic        e_ack;
    logic [1:0]  e_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vr, input logic [12:0] va, input logic gr, input logic gw,
                     input logic [12:0] ga, input logic [1:0] gd, input logic e_we,
                     input logic [12:0] e_addr, input logic e_vv, input logic [1:0] e_vd,
                     input logic e_ack, input logic [1:0] e_rd);
    vec_t v;
    v.vr = vr; v.va = va; v.gr = gr; v.gw = gw; v.ga = ga; v.gd = gd;
    v.e_we = e_we; v.e_addr = e_addr; v.e_vv = e_vv; v.e_vd = e_vd;
    v.e_ack = e_ack; v.e_rd = e_rd;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  int n_valid;
  int n_we;
  int n_ack;
  int ack_at;

  initial begin
    n_vec = 0;
    n_bad = 0;
    preload = 1'b1;
    reset = 1'b1;
    vga_req = 1'b0; vga_addr = '0;
    game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;
    tick();
    preload = 1'b0;
    tick();
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_vga_valid", vga_valid, 0);
    check("rst_game_ack", game_ack, 0);
    reset = 1'b0;

    // VGA stream, game write, game read, then VGA read-after-write
    add(1, 0,   0, 0, 0,   0,  0, 0,   0, 0, 0, 0);
    add(1, 1,   0, 0, 0,   0,  0, 1,   0, 0, 0, 0);
    add(1, 2,   0, 0, 0,   0,  0, 2,   1, 0, 0, 0);
    add(1, 3,   0, 0, 0,   0,  0, 3,   1, 1, 0, 0);
    add(0, 0,   0, 0, 0,   0,  0, 3,   1, 2, 0, 0);
    add(0, 0,   0, 0, 0,   0,  0, 3,   1, 3, 0, 0);
    add(0, 0,   0, 0, 0,   0,  0, 3,   0, 0, 0, 0);
    add(0, 0,   1, 1, 100, 2,  1, 100, 0, 0, 0, 0);
    add(0, 0,   1, 1, 100, 2,  0, 100, 0, 0, 0, 0);
    add(0, 0,   1, 1, 100, 2,  0, 100, 0, 0, 1, 0);
    add(0, 0,   0, 0, 100, 0,  0, 100, 0, 0, 0, 0);
    add(0, 0,   1, 0, 100, 0,  0, 100, 0, 0, 0, 0);
    add(0, 0,   1, 0, 100, 0,  0, 100, 0, 0, 0, 0);
    add(0, 0,   1, 0, 100, 0,  0, 100, 0, 0, 1, 2);
    add(0, 0,   0, 0, 100, 0,  0, 100, 0, 0, 0, 0);
    add(1, 100, 0, 0, 0,   0,  0, 100, 0, 0, 0, 0);
    add(0, 0,   0, 0, 0,   0,  0, 100, 0, 0, 0, 0);
    add(0, 0,   0, 0, 0,   0,  0, 100, 1, 2, 0, 0);

    foreach (tbl[i]) begin
      vga_req = tbl[i].vr; vga_addr = tbl[i].va;
      game_req = tbl[i].gr; game_we = tbl[i].gw;
      game_addr = tbl[i].ga; game_wdata = tbl[i].gd;
      tick();
      check($sformatf("v%0d_sram_we", i), sram_we, tbl[i].e_we);
      check($sformatf("v%0d_sram_addr", i), sram_addr, tbl[i].e_addr);
      check($sformatf("v%0d_vga_valid", i), vga_valid, tbl[i].e_vv);
      if (tbl[i].e_vv) check($sformatf("v%0d_vga_data", i), vga_data, tbl[i].e_vd);
      check($sformatf("v%0d_game_ack", i), game_ack, tbl[i].e_ack);
      if (tbl[i].e_ack && !tbl[i].gw) check($sformatf("v%0d_game_rdata", i), game_rdata, tbl[i].e_rd);
    end
    vga_req = 1'b0;
    game_req = 1'b0;

`ifndef STARVE_GUARD_EN
    // Contention: game waits behind ten VGA slots
    n_valid = 0;
    for (int c = 0; c < 10; c++) begin
      vga_req = 1'b1; vga_addr = 13'(c);
      game_req = 1'b1; game_we = 1'b1; game_addr = 200; game_wdata = 2'd3;
      tick();
      check("t3_game_blocked", sram_we, 0);
      if (vga_valid) n_valid++;
    end
    vga_req = 1'b0;
    tick();
    check("t3_grant_we", sram_we, 1);
    check("t3_grant_addr", sram_addr, 200);
    if (vga_valid) n_valid++;
    tick();
    check("t3_ack_early", game_ack, 0);
    if (vga_valid) n_valid++;
    tick();
    check("t3_ack", game_ack, 1);
    if (vga_valid) n_valid++;
    game_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (vga_valid) n_valid++;
    end
    check("t3_valid_count", n_valid, 10);
    check("t3_written", mem[200], 3);
`endif

    // Requester holds req one cycle past ack
    game_req = 1'b1; game_we = 1'b1; game_addr = 300; game_wdata = 2'd1;
    n_we = 0; n_ack = 0; ack_at = -1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (sram_we) n_we++;
      if (game_ack) begin
        n_ack++;
        ack_at = c;
      end else if (ack_at >= 0 && c == ack_at + 1) begin
        game_req = 1'b0;
      end
    end
    game_req = 1'b0;
    check("t4_we_pulses", n_we, 1);
    check("t4_acks", n_ack, 1);

    // Reset one cycle after a game write grant
    game_req = 1'b1; game_we = 1'b1; game_addr = 400; game_wdata = 2'd3;
    tick();
    check("t5_grant", sram_we, 1);
    reset = 1'b1;
    game_req = 1'b0;
    tick();
    check("t5_sram_addr", sram_addr, 0);
    check("t5_sram_we", sram_we, 0);
    check("t5_sram_wdata", sram_wdata, 0);
    check("t5_vga_valid", vga_valid, 0);
    check("t5_vga_data", vga_data, 0);
    check("t5_game_ack", game_ack, 0);
    check("t5_game_rdata", game_rdata, 0);
    reset = 1'b0;
    n_ack = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (game_ack) n_ack++;
    end
    check("t5_no_ack", n_ack, 0);

`ifdef STARVE_GUARD_EN
    // Forced game read after four blocked cycles; the dropped pixel repeats
    reset = 1'b1;
    tick();
    reset = 1'b0;
    game_req = 1'b1; game_we = 1'b0; game_addr = 100;
    for (int c = 0; c < 10; c++) begin
      vga_req = 1'b1; vga_addr = 13'(c % 4);
      tick();
      if (c < 4) check($sformatf("t6_vga_slot%0d", c), sram_addr, c % 4);
      if (c == 4) check("t6_forced_grant", sram_addr, 100);
      if (c >= 2) check($sformatf("t6_valid%0d", c), vga_valid, 1);
      if (c == 5) check("t6_data_before", vga_data, 3);
      if (c == 6) begin
        check("t6_data_repeat", vga_data, 3);
        check("t6_ack", game_ack, 1);
        check("t6_rdata", game_rdata, 2);
        game_req = 1'b0;
      end
      if (c == 7) check("t6_data_after", vga_data, 1);
    end
    vga_req = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/board_sram_arbiter.md
Name: board_sram_arbiter

Overview:
- Shares the single-port synchronous board SRAM (one 2-bit cell code per grid cell: empty/snake/food/wall) between two requesters: the VGA pixel reader and the snake game logic.
- VGA reads are streaming with fixed latency and always take priority.
- Game reads and writes use a req/ack handshake and are served in free slots, normally during blanking.
- Sits between the vga_wrapper pixel path, the game FSM and the board SRAM.

Parameters:
- ADDR_W, 13, SRAM address width (covers the 80x60 = 4800-cell grid).
- DATA_W, 2, cell code width.
- STARVE_LIMIT, 64, game wait cycles before forced grant (STARVE_GUARD_EN only).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vga_req  in  1  VGA read request this cycle; no backpressure.
- vga_addr  in  ADDR_W  VGA read address.
- vga_data  out  DATA_W  VGA read data.
- vga_valid  out  1  vga_data valid this cycle.
- game_req  in  1  game access request; held until game_ack.
- game_we  in  1  1 = write, 0 = read; stable while game_req is high.
- game_addr  in  ADDR_W  game address; stable while game_req is high.
- game_wdata  in  DATA_W  game write data.
- game_ack  out  1  one-cycle completion pulse.
- game_rdata  out  DATA_W  read data; valid when game_ack=1 and the access was a read.
- sram_addr  out  ADDR_W  SRAM address (registered).
- sram_we  out  1  SRAM write enable (registered).
- sram_wdata  out  DATA_W  SRAM write data (registered).
- sram_rdata  in  DATA_W  SRAM read data; valid one cycle after sram_addr is presented.

Behaviour:
- Reset (synchronous, reset=1 at an edge): all outputs go to 0 (sram_addr, sram_we, sram_wdata, vga_data, vga_valid, game_ack, game_rdata). The grant pipeline, busy flag and starve counter clear.
- Reset mid-operation: in-flight accesses are discarded. No game_ack or vga_valid is issued for them. sram_we=0 from the reset edge.
- Grant FSM states:
  - IDLE
  - GRANT_VGA
  - GRANT_GAME
  - GAME_WAIT (game op in flight, including the ack cycle)
- Arbitration at sampling edge k, in priority order:
  1. vga_req=1 -> VGA slot.
  2. Else game_req=1 and game not busy -> game slot.
  3. Else idle slot: sram_we=0, sram_addr holds its last value.
- Pipeline: the slot owner is registered at edge k and sram_addr/we/wdata are driven from edge k. The SRAM samples at edge k+1 and sram_rdata is valid after it. The result is registered at edge k+2.
- VGA: vga_valid=1 and vga_data=sram_rdata for one cycle after edge k+2. Fixed latency 2, fully pipelined; back-to-back requests give back-to-back valids.
- Game write: sram_we=1 for exactly one cycle (after edge k). game_ack=1 for one cycle after edge k+2.
- Game read: sram_we=0. game_ack=1 with game_rdata=sram_rdata after edge k+2.
- Busy flag: set at the game grant edge, cleared at the edge after the game_ack cycle. No new game grant while busy, nor at the edge where game_ack was high. A requester that drops req on seeing ack therefore gets exactly one service. Earliest back-to-back game grant is edge k+4.
- Single port only: a VGA read and a game write never occur in the same cycle. Read-after-write to the same address returns the new data when the write slot precedes the read slot.
- Without the optional feature, game_req with vga_req continuously high waits indefinitely. No data loss; ack is deferred.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- Defined:
  - A counter increments each edge where game_req=1, game is not busy and the game is not granted.
  - On reaching STARVE_LIMIT, the next sampling edge grants the game even if vga_req=1.
  - That VGA request is dropped, but vga_valid still pulses at k+2 with vga_data repeating the previously delivered value, so pixel timing is preserved.
  - The counter clears on any game grant or on reset.
- Undefined: no counter. VGA has strict priority as described in Behaviour.

Test Plan:
1. SRAM preloaded addr0..3 = 0,1,2,3; vga_req high for 4 cycles, addr 0..3 -> vga_valid high 4 consecutive cycles starting 2 cycles after first sample, data 0,1,2,3.
2. vga_req=0; game write addr 100, data 2'b10 -> single sram_we pulse with sram_addr=100; game_ack 2 cycles after grant. Then game read addr 100 -> game_ack with game_rdata=2'b10.
3. vga_req and game_req both high for 10 cycles, then vga_req low -> 10 vga_valids; game granted at first edge sampling vga_req=0; ack 2 cycles later.
4. Requester keeps game_req high one cycle past ack -> exactly one sram_we pulse and one game_ack.
5. reset pulsed the cycle after a game write grant -> no game_ack; all outputs 0 after reset edge; sram_we 0.
6. STARVE_GUARD_EN, STARVE_LIMIT=4; vga_req held high, game_req high -> game granted after 4 waiting cycles; vga_valid unbroken, with that slot's vga_data equal to the previous value.
